// File: rtl/edge_wait_seq_pkg.sv
// Shared types and constants for the edge/event wait sequencer.
// Condition vector bit positions, the condition vector type and the
// sequencer state encoding live here so the top and the bench agree.
package edge_wait_seq_pkg;

    localparam int COND_POS_A = 0;
    localparam int COND_NEG_A = 1;
    localparam int COND_POS_B = 2;
    localparam int COND_NEG_B = 3;
    localparam int COND_EVT   = 4;
    localparam int COND_W     = 5;

    typedef logic [COND_W-1:0] cond_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

endpackage : edge_wait_seq_pkg

// File: rtl/edge_wait_edge_det.sv
// Edge detector for one level signal.
// Registers the previous sample and a prime flag; no edge is reported until
// one real sample has been taken, so the reset value of the previous-sample
// flop can never masquerade as an edge.
module edge_wait_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pos,
    output logic neg
);

    logic prev_q;
    logic prime_q;

    // Capture the previous sample and arm the detector after the first sample.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its inputs regardless of statement order.
        if (rst) begin
            prev_q  <= 1'b0;
            prime_q <= 1'b0;
        end else begin
            prev_q  <= d;
            prime_q <= 1'b1;
        end
    end

    assign pos = prime_q &  d & ~prev_q;
    assign neg = prime_q & ~d &  prev_q;

endmodule : edge_wait_edge_det

// File: rtl/edge_wait_sequencer.sv
// Edge/event wait sequencer.
// Walks NSTEPS wait steps; each step waits for an OR of edge/event conditions
// on sig_a, sig_b and evt selected by its slice of STEP_MASKS (step 0 in the
// LSB slice). A match produces a one-cycle hit pulse on the next cycle with
// the step index and the free-running timestamp of the match cycle. After the
// last step the sequencer either wraps (LOOP=1) or parks in DONE until re-armed.
// Optional trace output is compiled in with the macro EDGE_WAIT_SEQ_TRACE_EN.
module edge_wait_sequencer
    import edge_wait_seq_pkg::*;
#(
    parameter int                        NSTEPS     = 4,
    parameter logic [NSTEPS*COND_W-1:0]  STEP_MASKS = {5'b00110, 5'b01001, 5'b10100, 5'b10001},
    parameter int                        TS_W       = 32,
    parameter int                        LOOP       = 0,
    localparam int                       SW         = (NSTEPS > 1) ? $clog2(NSTEPS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            arm,
    input  logic            sig_a,
    input  logic            sig_b,
    input  logic            evt,
    output logic            hit,
    output logic [SW-1:0]   hit_step,
    output logic [TS_W-1:0] hit_time,
    output logic [SW-1:0]   step,
    output logic            busy,
    output logic            done
);

    localparam logic [SW-1:0] LAST_STEP = SW'(NSTEPS - 1);

    state_t          state_q, state_d;
    logic [SW-1:0]   step_q, step_d;
    logic            hit_q, hit_d;
    logic [SW-1:0]   hit_step_q, hit_step_d;
    logic [TS_W-1:0] hit_time_q, hit_time_d;
    logic [TS_W-1:0] ts_q;

    logic  pos_a, neg_a, pos_b, neg_b;
    cond_t cond;
    cond_t step_mask;
    logic  match;
    logic  last_step;

    edge_wait_edge_det u_det_a (
        .clk (clk),
        .rst (rst),
        .d   (sig_a),
        .pos (pos_a),
        .neg (neg_a)
    );

    edge_wait_edge_det u_det_b (
        .clk (clk),
        .rst (rst),
        .d   (sig_b),
        .pos (pos_b),
        .neg (neg_b)
    );

    // Free-running timestamp, zero in the first cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // Assemble the condition vector and test it against the current step's mask.
    always_comb begin
        cond                = '0;
        cond[COND_POS_A]    = pos_a;
        cond[COND_NEG_A]    = neg_a;
        cond[COND_POS_B]    = pos_b;
        cond[COND_NEG_B]    = neg_b;
        cond[COND_EVT]      = evt;
        step_mask           = STEP_MASKS[int'(step_q)*COND_W +: COND_W];
        match               = |(cond & step_mask);
        last_step           = (step_q == LAST_STEP);
    end

    // Sequencer state and registered hit outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            hit_q      <= 1'b0;
            hit_step_q <= '0;
            hit_time_q <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            hit_q      <= hit_d;
            hit_step_q <= hit_step_d;
            hit_time_q <= hit_time_d;
        end
    end

    // Next-state logic: a match is consumed by the step that is current in the
    // match cycle only, because step_q changes on the same edge that registers the hit.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        step_d     = step_q;
        hit_d      = 1'b0;
        hit_step_d = hit_step_q;
        hit_time_d = hit_time_q;

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d = S_WAIT;
                    step_d  = '0;
                end
            end
            S_WAIT: begin
                if (match) begin
                    hit_d      = 1'b1;
                    hit_step_d = step_q;
                    hit_time_d = ts_q;
                    if (!last_step) begin
                        step_d = step_q + SW'(1);
                    end else if (LOOP != 0) begin
                        step_d = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (arm) begin
                    state_d = S_WAIT;
                    step_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef EDGE_WAIT_SEQ_TRACE_EN
    // Trace each match as it is registered and the transition into DONE.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_WAIT && match) begin
            $write("[%0d] step %0d hit cond=%05b\n", ts_q, step_q, cond);
            if (last_step && LOOP == 0) begin
                $write("*-* All Finished *-*\n");
            end
        end
    end
`else
    // Trace disabled: no simulation-only logic in this build.
`endif

    assign hit      = hit_q;
    assign hit_step = hit_step_q;
    assign hit_time = hit_time_q;
    assign step     = step_q;
    assign busy     = (state_q == S_WAIT);
    assign done     = (state_q == S_DONE);

endmodule : edge_wait_sequencer

// File: tb/tb_edge_wait_sequencer.sv
// Directed bench for edge_wait_sequencer.
// u_dut uses the default configuration (4 steps, LOOP=0, 32-bit timestamp);
// u_dut2 uses 2 evt-only steps with LOOP=1 and a 4-bit timestamp.
module tb_edge_wait_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        sig_a = 1'b0;
    logic        sig_b = 1'b1;
    logic        evt = 1'b0;
    logic        hit;
    logic [1:0]  hit_step;
    logic [31:0] hit_time;
    logic [1:0]  step;
    logic        busy;
    logic        done;

    logic        arm2 = 1'b0;
    logic        evt2 = 1'b0;
    logic        zero = 1'b0;
    logic        hit2;
    logic [0:0]  hit_step2;
    logic [3:0]  hit_time2;
    logic [0:0]  step2;
    logic        busy2;
    logic        done2;

    int errors = 0;
    int checks = 0;
    int tb_ts  = 0;

    edge_wait_sequencer u_dut (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm),
        .sig_a    (sig_a),
        .sig_b    (sig_b),
        .evt      (evt),
        .hit      (hit),
        .hit_step (hit_step),
        .hit_time (hit_time),
        .step     (step),
        .busy     (busy),
        .done     (done)
    );

    edge_wait_sequencer #(
        .NSTEPS     (2),
        .STEP_MASKS (10'b10000_10000),
        .TS_W       (4),
        .LOOP       (1)
    ) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm2),
        .sig_a    (zero),
        .sig_b    (zero),
        .evt      (evt2),
        .hit      (hit2),
        .hit_step (hit_step2),
        .hit_time (hit_time2),
        .step     (step2),
        .busy     (busy2),
        .done     (done2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   ts;
        logic arm;
        logic a;
        logic b;
        logic evt;
        logic ehit;
        int   ehs;
        int   eht;
        int   estep;
        logic ebusy;
        logic edone;
    } vec_t;

    typedef struct {
        int ts;
        int ehs;
        int eht;
        int estep;
    } loop_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at ts=%0d: got %0d expected %0d", name, tb_ts, act, exp);
        end
    endtask

    // Advance one clock; outputs are read 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        tb_ts++;
    endtask

    // Run idle cycles up to the target timestamp; nothing may hit meanwhile.
    task automatic idle_to(input int target);
        while (tb_ts < target) begin
            tick();
            check("idle_no_hit", 32'(hit | hit2), 32'd0);
        end
    endtask

    task automatic check_reset_state();
        check("rst_hit",      32'(hit),      32'd0);
        check("rst_hit_step", 32'(hit_step), 32'd0);
        check("rst_hit_time", hit_time,      32'd0);
        check("rst_step",     32'(step),     32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
    endtask

    vec_t      vecs[11];
    loop_vec_t lvecs[5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          ts arm a  b  evt  hit hs  ht  st busy done
        vecs[0]  = '{ 5, 1, 0, 1, 0,  0,  0,  0, 0, 1, 0};  // arm, no edges
        vecs[1]  = '{10, 0, 0, 1, 1,  1,  0, 10, 1, 1, 0};  // evt -> step 0
        vecs[2]  = '{14, 0, 0, 0, 0,  0,  0, 10, 1, 1, 0};  // negedge_b not in step 1
        vecs[3]  = '{16, 0, 0, 0, 1,  1,  1, 16, 2, 1, 0};  // evt -> step 1
        vecs[4]  = '{18, 0, 1, 0, 0,  1,  2, 18, 3, 1, 0};  // posedge_a -> step 2
        vecs[5]  = '{22, 0, 0, 0, 0,  1,  3, 22, 3, 0, 1};  // negedge_a -> step 3, DONE
        vecs[6]  = '{23, 0, 0, 0, 1,  0,  3, 22, 3, 0, 1};  // DONE ignores evt
        vecs[7]  = '{24, 1, 0, 0, 1,  0,  3, 22, 0, 1, 0};  // re-arm, evt in arm cycle ignored
        vecs[8]  = '{26, 0, 0, 0, 1,  1,  0, 26, 1, 1, 0};  // evt -> step 0
        vecs[9]  = '{27, 1, 0, 0, 0,  0,  0, 26, 1, 1, 0};  // arm in WAIT ignored
        vecs[10] = '{28, 0, 0, 0, 1,  1,  1, 28, 2, 1, 0};  // evt -> step 1, now at step 2

        lvecs[0] = '{ 6, 0,  6, 1};
        lvecs[1] = '{ 9, 1,  9, 0};
        lvecs[2] = '{12, 0, 12, 1};
        lvecs[3] = '{15, 1, 15, 0};
        lvecs[4] = '{17, 0,  1, 1};  // 17 wraps to 1 in a 4-bit timestamp

        // Reset held 3 cycles with sig_a=0, sig_b=1.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tb_ts = 0;
        check_reset_state();
        check("rst_busy2", 32'(busy2), 32'd0);

        // Main sequence, DONE handling and re-arm on the default configuration.
        for (int i = 0; i < 11; i++) begin
            idle_to(vecs[i].ts);
            arm   = vecs[i].arm;
            sig_a = vecs[i].a;
            sig_b = vecs[i].b;
            evt   = vecs[i].evt;
            tick();
            arm = 1'b0;
            evt = 1'b0;
            check($sformatf("v%0d_hit", i),      32'(hit),      32'(vecs[i].ehit));
            check($sformatf("v%0d_hit_step", i), 32'(hit_step), vecs[i].ehs);
            check($sformatf("v%0d_hit_time", i), hit_time,      vecs[i].eht);
            check($sformatf("v%0d_step", i),     32'(step),     vecs[i].estep);
            check($sformatf("v%0d_busy", i),     32'(busy),     32'(vecs[i].ebusy));
            check($sformatf("v%0d_done", i),     32'(done),     32'(vecs[i].edone));
        end

        // Reset at step 2 aborts the sequence; sig_a rises during reset.
        check("pre_abort_step", 32'(step), 32'd2);
        rst   = 1'b1;
        sig_a = 1'b1;
        tick();
        tb_ts = 0;
        rst   = 1'b0;
        check_reset_state();

        // Steady sig_a=1 after release must not look like a posedge.
        idle_to(2);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("rearm_busy", 32'(busy), 32'd1);
        check("rearm_hit",  32'(hit),  32'd0);
        idle_to(5);
        check("steady_a_step", 32'(step), 32'd0);

        // negedge_a is not in step 0's mask.
        sig_a = 1'b0;
        tick();
        check("neg_a_hit",  32'(hit),  32'd0);
        check("neg_a_step", 32'(step), 32'd0);

        // posedge_a and evt together: exactly one hit, one step advance.
        sig_a = 1'b1;
        evt   = 1'b1;
        tick();
        evt = 1'b0;
        check("dual_hit",      32'(hit),      32'd1);
        check("dual_hit_step", 32'(hit_step), 32'd0);
        check("dual_hit_time", hit_time,      32'd6);
        check("dual_step",     32'(step),     32'd1);
        tick();
        check("dual_no_second_hit", 32'(hit),  32'd0);
        check("dual_step_held",     32'(step), 32'd1);

        // Looping configuration with timestamp wrap.
        rst = 1'b1;
        tick();
        tb_ts = 0;
        rst   = 1'b0;
        check("loop_rst_busy", 32'(busy2), 32'd0);
        idle_to(2);
        arm2 = 1'b1;
        tick();
        arm2 = 1'b0;
        check("loop_arm_busy", 32'(busy2), 32'd1);
        for (int i = 0; i < 5; i++) begin
            idle_to(lvecs[i].ts);
            evt2 = 1'b1;
            tick();
            evt2 = 1'b0;
            check($sformatf("l%0d_hit", i),      32'(hit2),      32'd1);
            check($sformatf("l%0d_hit_step", i), 32'(hit_step2), lvecs[i].ehs);
            check($sformatf("l%0d_hit_time", i), 32'(hit_time2), lvecs[i].eht);
            check($sformatf("l%0d_step", i),     32'(step2),     lvecs[i].estep);
            check($sformatf("l%0d_done", i),     32'(done2),     32'd0);
            check($sformatf("l%0d_busy", i),     32'(busy2),     32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_edge_wait_sequencer
